rsp_vote_collector: RTL and testbench
=====================================

# rsp_vote_collector

Collects repeated PUF evaluations from the response generator and reduces them to one stable response word. It requests one evaluation at a time, captures each `rsp_write`/`rsp_clean` pair, and counts per bit how often the two phases differ. After `REPS` samples it produces a majority-vote response and a per-bit stability mask. It sits downstream of the response generator and replaces single-shot capture in the top-level FSM.

## Interface
- `WIDTH`, 32, response width in bits.
- `REPS`, 16, evaluations per collection; legal range 1..255.
- `TIMEOUT`, 1024, maximum cycles to wait for `rsp_valid` after a request; used only with `RSP_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset, asynchronous, active-high; clears all state and outputs.
- `start`  in  1  one-cycle pulse that begins a collection; ignored while `busy` is high.
- `eval_req`  out  1  one-cycle pulse requesting one evaluation from the generator.
- `rsp_valid`  in  1  one-cycle strobe; `rsp_write` and `rsp_clean` are valid in this cycle.
- `rsp_write`  in  WIDTH  write-phase response.
- `rsp_clean`  in  WIDTH  clean-phase response.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `response`, `stable_mask` and `timeout` are valid in this cycle.
- `response`  out  WIDTH  majority-vote response.
- `stable_mask`  out  WIDTH  bit = 1 when all `REPS` samples of that bit agreed.
- `timeout`  out  1  last collection was aborted by the watchdog.

## Operation
- Raw sample bit: `raw[i] = rsp_write[i] ^ rsp_clean[i]`.
- Per-bit counter `ones_cnt[i]`:
  - width `$clog2(REPS+1)`;
  - cleared on accepted `start`;
  - incremented on each accepted `rsp_valid` where `raw[i]` = 1;
  - cannot overflow.
- Sample counter: 8 bits; counts accepted samples.
- FSM states:
  - IDLE: `start` → clear all counters, clear `timeout` → REQ.
  - REQ: `eval_req` = 1 for exactly this cycle → WAIT.
  - WAIT, `rsp_valid` = 1: accumulate into the counters and increment the sample counter. If this is the `REPS`-th sample → EVAL, else → REQ.
  - WAIT, `rsp_valid` = 0: stay in WAIT.
  - EVAL: register the results, then → DONE.
    - `response[i] = (2*ones_cnt[i] > REPS)`; a tie gives 0.
    - `stable_mask[i] = (ones_cnt[i]==0) || (ones_cnt[i]==REPS)`.
  - DONE: `done` = 1 → IDLE.
- `rsp_valid` outside WAIT is ignored; there is no accumulation and no error.
- `start` while `busy` is high is ignored.
- `response` and `stable_mask` hold their values until the next EVAL or timeout abort.
- Reset mid-operation returns immediately to IDLE. All outputs go to their reset values and partial counts are discarded.

## Timing
- Reset values: `eval_req` = 0, `busy` = 0, `done` = 0, `response` = 0, `stable_mask` = 0, `timeout` = 0.
- Outputs are registered; no combinational path from any input to any output.
- `start` sampled high at cycle 0:
  - `busy` and `eval_req` go high at cycle 1;
  - the first `rsp_valid` is accepted no earlier than cycle 2.
- Each sample costs at least 2 cycles (REQ + WAIT).
- Minimum collection latency: `start` at cycle 0 → `done` at cycle `2*REPS+2`. With `REPS`=16 this is cycle 34.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that cycle.

## Configuration
- `RSP_TIMEOUT_EN` defined:
  - a wait counter runs in WAIT and is cleared on every entry to WAIT;
  - after `TIMEOUT` cycles in WAIT without `rsp_valid`, the FSM → DONE;
  - on that abort, `timeout` = 1 and `response` = `stable_mask` = 0;
  - `done` pulses as usual.
- `RSP_TIMEOUT_EN` undefined:
  - no wait counter; WAIT waits indefinitely;
  - `timeout` is tied to 0.

## Test plan
- Stable pattern, `REPS`=16: every sample has `rsp_write`=32'hFFFF_FFFF, `rsp_clean`=32'h0F0F_0F0F → `response`=32'hF0F0_F0F0, `stable_mask`=32'hFFFF_FFFF, `done` at cycle 34 with an immediate responder.
- Bit 0 has raw = 1 in 9 of 16 samples and bit 1 in exactly 8; all other bits always 0 → `response`=32'h0000_0001, `stable_mask`=32'hFFFF_FFFC.
- `start` pulsed during a collection, and `rsp_valid` injected in IDLE and REQ → no effect: exactly 16 `eval_req` pulses, result identical to the clean run.
- `rst` asserted after 7 samples → next cycle `busy`=0 and all outputs 0. A fresh `start` then yields a result counting only new samples.
- With `RSP_TIMEOUT_EN` and `TIMEOUT`=1024: responder stops after 5 samples → `done` with `timeout`=1 and `response`=`stable_mask`=0, 1024 cycles into WAIT. The next `start` clears `timeout`.
- `REPS`=1: a single sample with raw=32'hA5A5_A5A5 → `response`=32'hA5A5_A5A5, `stable_mask`=32'hFFFF_FFFF, `done` at cycle 4.

Source files
------------

// File: rtl/rsp_vote_collector_if.sv
// rsp_vote_collector_if
//   Handshake bundle between a controller, the PUF response generator and
//   rsp_vote_collector.
//   master : drives start / rsp_valid / rsp_write / rsp_clean, observes results
//   slave  : the collector; drives eval_req / busy / done / response /
//            stable_mask / timeout
interface rsp_vote_collector_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             eval_req;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_write;
  logic [WIDTH-1:0] rsp_clean;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] response;
  logic [WIDTH-1:0] stable_mask;
  logic             timeout;

  modport master (
    output start, rsp_valid, rsp_write, rsp_clean,
    input  eval_req, busy, done, response, stable_mask, timeout
  );

  modport slave (
    input  start, rsp_valid, rsp_write, rsp_clean,
    output eval_req, busy, done, response, stable_mask, timeout
  );
endinterface

// File: rtl/rsp_vote_collector.sv
// rsp_vote_collector
//   Requests REPS PUF evaluations one at a time, counts per bit how often the
//   write and clean phases differ, and reduces the samples to a majority-vote
//   response plus a per-bit stability mask.
//
//   Ports:
//     clk  : block clock
//     rst  : asynchronous, active-high reset
//     bus  : rsp_vote_collector_if.slave (start, eval_req, rsp_valid,
//            rsp_write, rsp_clean, busy, done, response, stable_mask, timeout)
//
//   Optional feature: define RSP_TIMEOUT_EN to enable the WAIT watchdog.
//   Without it WAIT waits indefinitely and timeout is tied low.
//
//   state  | meaning
//   IDLE   | waiting for start
//   REQ    | eval_req asserted for one cycle
//   WAIT   | waiting for rsp_valid, accumulate on arrival
//   EVAL   | register majority vote and stability mask
//   DONE   | done pulse, back to IDLE
module rsp_vote_collector #(
  parameter int WIDTH   = 32,
  parameter int REPS    = 16,
  parameter int TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst,
  rsp_vote_collector_if.slave bus
);

  localparam int CW = $clog2(REPS + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    ones_cnt [WIDTH];
  logic [7:0]       sample_cnt;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] vote;
  logic [WIDTH-1:0] agree;
  logic             eval_req_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] response_q;
  logic [WIDTH-1:0] stable_q;

  assign raw = bus.rsp_write ^ bus.rsp_clean;

  always_comb begin
    int cnt_i;
    vote  = '0;
    agree = '0;
    cnt_i = 0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_i    = int'(ones_cnt[i]);
      // strict majority; a tie (even REPS) votes 0
      vote[i]  = (2 * cnt_i) > REPS;
      agree[i] = (cnt_i == 0) || (cnt_i == REPS);
    end
  end

`ifdef RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_q;
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.eval_req    = eval_req_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.response    = response_q;
  assign bus.stable_mask = stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= '0;
      eval_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= '0;
      stable_q   <= '0;
`ifdef RSP_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      eval_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= '0;
            sample_cnt <= '0;
`ifdef RSP_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            eval_req_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef RSP_TIMEOUT_EN
          // down-counter reaches zero on the TIMEOUT-th idle WAIT cycle
          wait_cnt <= TW'(TIMEOUT - 1);
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rsp_valid) begin
            for (int i = 0; i < WIDTH; i++) ones_cnt[i] <= ones_cnt[i] + CW'(raw[i]);
            sample_cnt <= sample_cnt + 8'd1;
            if (sample_cnt == 8'(REPS - 1)) begin
              state <= S_EVAL;
            end else begin
              eval_req_q <= 1'b1;
              state      <= S_REQ;
            end
          end
`ifdef RSP_TIMEOUT_EN
          else if (wait_cnt == '0) begin
            timeout_q  <= 1'b1;
            response_q <= '0;
            stable_q   <= '0;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
`endif
        end
        S_EVAL: begin
          response_q <= vote;
          stable_q   <= agree;
          done_q     <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_vote_collector.sv
module tb_rsp_vote_collector;
  localparam int W = 32;
  localparam int R = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsp_vote_collector_if #(.WIDTH(W)) bus ();
  rsp_vote_collector_if #(.WIDTH(W)) bus1 ();

  rsp_vote_collector #(.WIDTH(W), .REPS(R), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rsp_vote_collector #(.WIDTH(W), .REPS(1), .TIMEOUT(1024)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_wr[$];
  logic [31:0] q_cl[$];

  // Reference: count differing phases per bit over the first n samples.
  function automatic void model(input int n, input int reps,
                                output logic [31:0] resp, output logic [31:0] mask);
    resp = '0;
    mask = '0;
    for (int b = 0; b < 32; b++) begin
      int cnt = 0;
      for (int s = 0; s < n; s++) cnt += int'(q_wr[s][b] ^ q_cl[s][b]);
      resp[b] = (cnt * 2) > reps;
      mask[b] = (cnt == 0) || (cnt == reps);
    end
  endfunction

  task automatic fill_random();
    q_wr.delete(); q_cl.delete();
    for (int s = 0; s < R; s++) begin
      q_wr.push_back($urandom);
      q_cl.push_back($urandom);
    end
  endtask

  // Drives one collection from a negedge; returns at the negedge where done
  // is seen (or after the abort request). lat counts cycles after start.
  task automatic run_collect(input int max_delay, input bit noise, input int abort_after,
                             input int stall_idx, input int stall_len,
                             output int lat, output int n_req, output bit got_done);
    int idx = 0;
    int delay = 0;
    bit armed = 0;
    lat = 0; n_req = 0; got_done = 0;
    if (noise) begin
      bus.rsp_valid = 1'b1; bus.rsp_write = $urandom; bus.rsp_clean = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.rsp_valid = noise;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      lat = c;
      bus.start = 1'b0;
      bus.rsp_valid = 1'b0;
      if (bus.done) begin got_done = 1; break; end
      if (bus.eval_req) begin
        n_req++;
        if (abort_after > 0 && idx == abort_after) break;
        armed = 1;
        delay = (idx == stall_idx) ? stall_len : int'($urandom_range(max_delay, 0));
        if (noise && $urandom_range(1, 0) == 1) begin
          bus.rsp_valid = 1'b1; bus.rsp_write = $urandom; bus.rsp_clean = $urandom;
        end
      end else if (armed) begin
        if (delay == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_write = q_wr[idx];
          bus.rsp_clean = q_cl[idx];
          idx++;
          armed = 0;
        end else begin
          delay--;
        end
        if (noise && $urandom_range(7, 0) == 0) bus.start = 1'b1;
      end else if (noise) begin
        bus.rsp_valid = 1'b1; bus.rsp_write = $urandom; bus.rsp_clean = $urandom;
        bus.start = 1'b1;
      end
    end
    if (!got_done && abort_after == 0) begin
      vectors++; miscompares++;
      $display("FAIL done_wait: no done within cycle budget, got busy=%b", bus.busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.eval_req !== 1'b0) begin miscompares++; $display("FAIL rst_eval_req: got %b expected 0", bus.eval_req); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    vectors++; if (bus.response !== 32'h0) begin miscompares++; $display("FAIL rst_response: got %h expected 0", bus.response); end
    vectors++; if (bus.stable_mask !== 32'h0) begin miscompares++; $display("FAIL rst_mask: got %h expected 0", bus.stable_mask); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout); end
  endtask

  task automatic test_stable();
    int lat, nreq; bit gd;
    q_wr.delete(); q_cl.delete();
    for (int s = 0; s < R; s++) begin q_wr.push_back(32'hFFFF_FFFF); q_cl.push_back(32'h0F0F_0F0F); end
    run_collect(0, 0, 0, -1, 0, lat, nreq, gd);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL stable_latency: got %0d expected 34", lat); end
    vectors++; if (nreq !== R) begin miscompares++; $display("FAIL stable_nreq: got %0d expected %0d", nreq, R); end
    vectors++; if (bus.response !== 32'hF0F0_F0F0) begin miscompares++; $display("FAIL stable_resp: got %h expected f0f0f0f0", bus.response); end
    vectors++; if (bus.stable_mask !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL stable_mask: got %h expected ffffffff", bus.stable_mask); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stable_busy_fall: got %b expected 0", bus.busy); end
  endtask

  task automatic test_tie();
    int lat, nreq; bit gd;
    int p0[16]; int p1[16];
    for (int i = 0; i < 16; i++) begin p0[i] = i; p1[i] = i; end
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0)); t = p0[i]; p0[i] = p0[j]; p0[j] = t;
      j = int'($urandom_range(i, 0)); t = p1[i]; p1[i] = p1[j]; p1[j] = t;
    end
    q_wr.delete(); q_cl.delete();
    for (int s = 0; s < R; s++) begin
      logic [31:0] w, rw;
      w = $urandom;
      rw = {30'b0, (p1[s] < 8), (p0[s] < 9)};
      q_wr.push_back(w); q_cl.push_back(w ^ rw);
    end
    run_collect(3, 0, 0, -1, 0, lat, nreq, gd);
    vectors++; if (bus.response !== 32'h0000_0001) begin miscompares++; $display("FAIL tie_resp: got %h expected 00000001", bus.response); end
    vectors++; if (bus.stable_mask !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL tie_mask: got %h expected fffffffc", bus.stable_mask); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, nreq; bit gd; logic [31:0] er, em;
    for (int k = 0; k < 4; k++) begin
      fill_random();
      model(R, R, er, em);
      run_collect(4, 0, 0, -1, 0, lat, nreq, gd);
      vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL rand_resp[%0d]: got %h expected %h", k, bus.response, er); end
      vectors++; if (bus.stable_mask !== em) begin miscompares++; $display("FAIL rand_mask[%0d]: got %h expected %h", k, bus.stable_mask, em); end
      vectors++; if (nreq !== R) begin miscompares++; $display("FAIL rand_nreq[%0d]: got %0d expected %0d", k, nreq, R); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nreq; bit gd; logic [31:0] er, em;
    for (int k = 0; k < 2; k++) begin
      fill_random();
      model(R, R, er, em);
      run_collect(0, 0, 0, -1, 0, lat, nreq, gd);
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d expected 34", k, lat); end
      vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL b2b_resp[%0d]: got %h expected %h", k, bus.response, er); end
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy[%0d]: got %b expected 0", k, bus.busy); end
    end
  endtask

  task automatic test_noise();
    int lat, nreq; bit gd; logic [31:0] er, em;
    fill_random();
    model(R, R, er, em);
    run_collect(2, 0, 0, -1, 0, lat, nreq, gd);
    @(negedge clk);
    run_collect(2, 1, 0, -1, 0, lat, nreq, gd);
    vectors++; if (nreq !== R) begin miscompares++; $display("FAIL noise_nreq: got %0d expected %0d", nreq, R); end
    vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL noise_resp: got %h expected %h", bus.response, er); end
    vectors++; if (bus.stable_mask !== em) begin miscompares++; $display("FAIL noise_mask: got %h expected %h", bus.stable_mask, em); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, nreq; bit gd; logic [31:0] er, em;
    q_wr.delete(); q_cl.delete();
    for (int s = 0; s < R; s++) begin q_wr.push_back(32'hFFFF_FFFF); q_cl.push_back(32'h0); end
    run_collect(1, 0, 7, -1, 0, lat, nreq, gd);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    vectors++; if ({bus.eval_req, bus.done, bus.timeout} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got %b expected 000", {bus.eval_req, bus.done, bus.timeout}); end
    vectors++; if ({bus.response, bus.stable_mask} !== 64'h0) begin miscompares++; $display("FAIL midrst_data: got %h expected 0", {bus.response, bus.stable_mask}); end
    rst = 1'b0;
    @(negedge clk);
    fill_random();
    model(R, R, er, em);
    run_collect(1, 0, 0, -1, 0, lat, nreq, gd);
    vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL midrst_resp: got %h expected %h", bus.response, er); end
    vectors++; if (bus.stable_mask !== em) begin miscompares++; $display("FAIL midrst_mask: got %h expected %h", bus.stable_mask, em); end
    @(negedge clk);
  endtask

`ifdef RSP_TIMEOUT_EN
  task automatic test_timeout();
    int lat, nreq; bit gd; logic [31:0] er, em;
    fill_random();
    run_collect(0, 0, 0, 5, 100000, lat, nreq, gd);
    vectors++; if (lat !== 1036) begin miscompares++; $display("FAIL to_latency: got %0d expected 1036", lat); end
    vectors++; if (bus.timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", bus.timeout); end
    vectors++; if ({bus.response, bus.stable_mask} !== 64'h0) begin miscompares++; $display("FAIL to_data: got %h expected 0", {bus.response, bus.stable_mask}); end
    @(negedge clk);
    fill_random();
    model(R, R, er, em);
    run_collect(0, 0, 0, -1, 0, lat, nreq, gd);
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b expected 0", bus.timeout); end
    vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL to_after_resp: got %h expected %h", bus.response, er); end
    @(negedge clk);
  endtask
`else
  task automatic test_stall();
    int lat, nreq; bit gd; logic [31:0] er, em;
    fill_random();
    model(R, R, er, em);
    run_collect(0, 0, 0, 5, 1100, lat, nreq, gd);
    vectors++; if (lat !== 34 + 1100) begin miscompares++; $display("FAIL stall_latency: got %0d expected %0d", lat, 34 + 1100); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL stall_timeout: got %b expected 0", bus.timeout); end
    vectors++; if (bus.response !== er) begin miscompares++; $display("FAIL stall_resp: got %h expected %h", bus.response, er); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reps1();
    int lat = 0; bit armed = 0; bit gd = 0;
    bus1.start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      lat = c;
      bus1.start = 1'b0;
      bus1.rsp_valid = 1'b0;
      if (bus1.done) begin gd = 1; break; end
      if (bus1.eval_req) armed = 1;
      else if (armed) begin
        bus1.rsp_valid = 1'b1;
        bus1.rsp_write = $urandom;
        bus1.rsp_clean = bus1.rsp_write ^ 32'hA5A5_A5A5;
        armed = 0;
      end
    end
    vectors++; if (!gd || lat !== 4) begin miscompares++; $display("FAIL reps1_latency: got %0d (done=%b) expected 4", lat, gd); end
    vectors++; if (bus1.response !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL reps1_resp: got %h expected a5a5a5a5", bus1.response); end
    vectors++; if (bus1.stable_mask !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reps1_mask: got %h expected ffffffff", bus1.stable_mask); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_write = '0; bus.rsp_clean = '0;
    bus1.start = 1'b0; bus1.rsp_valid = 1'b0; bus1.rsp_write = '0; bus1.rsp_clean = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_stable();
    test_tie();
    test_random();
    test_back_to_back();
    test_noise();
    test_reset_mid();
`ifdef RSP_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reps1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
